// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - core-side and RAM-side signal bundle for the data-memory controller
//
// Purpose: groups the CPU load/store port and the data RAM port into one bundle.
// Modports:
//   slave  - the controller: takes cpu_req/we/addr/wdata/dmtype and ram_rdata,
//            drives cpu_rdata/ready/err, busy and ram_en/addr/wea/wdata.
//   master - the environment (core plus RAM): the mirror image of slave.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [2:0]        cpu_dmtype;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic              busy;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wea;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype, ram_rdata,
        output cpu_rdata, cpu_ready, cpu_err, busy,
        output ram_en, ram_addr, ram_wea, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype, ram_rdata,
        input  cpu_rdata, cpu_ready, cpu_err, busy,
        input  ram_en, ram_addr, ram_wea, ram_wdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access controller between CPU load/store port and word RAM
//
// Purpose: latches one byte-addressed access from the core, checks alignment,
// drives the word-addressed RAM with per-lane write enables and returns
// aligned, sign/zero-extended load data with a one-cycle ready pulse.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - dmem_ctrl_if.slave: cpu_* request/response and ram_* RAM port
// Parameters:
//   ADDR_W     - RAM word-address width
//   RD_LATENCY - cycles from ram_en to valid ram_rdata (1..4)
module dmem_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_RDWAIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

    state_t            state_q, state_d;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [2:0]        dmtype_q;
    logic              err_q;
    logic [1:0]        cnt_q;
    logic [31:0]       rdata_q;

    // Upper byte-address bits are outside the RAM and simply wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.cpu_addr[31:ADDR_W+2];

    function automatic logic is_misaligned(input logic [1:0] o, input logic [2:0] dt);
        case (dt)
            3'b001, 3'b010: is_misaligned = o[0];
            3'b011, 3'b100: is_misaligned = 1'b0;
            default:        is_misaligned = (o != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_lanes(input logic [1:0] o, input logic [2:0] dt);
        case (dt)
            3'b001, 3'b010: store_lanes = o[1] ? 4'b1100 : 4'b0011;
            3'b011, 3'b100: store_lanes = 4'b0001 << o;
            default:        store_lanes = 4'b1111;
        endcase
    endfunction

    // Replicate the narrow store value on every lane so wea alone picks the target bytes.
    function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [2:0] dt);
        case (dt)
            3'b001, 3'b010: store_data = {2{wd[15:0]}};
            3'b011, 3'b100: store_data = {4{wd[7:0]}};
            default:        store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] o,
                                                 input logic [2:0] dt);
        logic [31:0] sh;
        sh = rd >> {o, 3'b000};
        case (dt)
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b010:  load_extract = {16'h0000, sh[15:0]};
            3'b011:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_extract = {24'h000000, sh[7:0]};
            default: load_extract = rd;
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            dmtype_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.cpu_req) begin
                addr_q   <= bus.cpu_addr[ADDR_W+1:0];
                wdata_q  <= bus.cpu_wdata;
                we_q     <= bus.cpu_we;
                dmtype_q <= bus.cpu_dmtype;
                err_q    <= is_misaligned(bus.cpu_addr[1:0], bus.cpu_dmtype);
            end
            if (state_q == S_READ) begin
                cnt_q <= LAT_M1;
            end else if (state_q == S_RDWAIT) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (state_q == S_RDWAIT && cnt_q == 2'd0) begin
                rdata_q <= load_extract(bus.ram_rdata, addr_q[1:0], dmtype_q);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    if (is_misaligned(bus.cpu_addr[1:0], bus.cpu_dmtype)) begin
                        state_d = S_RESP;
                    end else if (bus.cpu_we) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE:  state_d = S_IDLE;
            S_READ:   state_d = S_RDWAIT;
            S_RDWAIT: if (cnt_q == 2'd0) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and latched access only.
    always_comb begin
        bus.cpu_rdata = rdata_q;
        bus.cpu_ready = 1'b0;
        bus.cpu_err   = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        bus.ram_en    = 1'b0;
        bus.ram_addr  = addr_q[ADDR_W+1:2];
        bus.ram_wea   = 4'b0000;
        bus.ram_wdata = store_data(wdata_q, dmtype_q);
        case (state_q)
            S_WRITE: begin
                bus.ram_en    = 1'b1;
                bus.ram_wea   = store_lanes(addr_q[1:0], dmtype_q) & {4{we_q}};
                bus.cpu_ready = 1'b1;
            end
            S_READ: begin
                bus.ram_en = 1'b1;
            end
            S_RESP: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_err   = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller that sits directly downstream of the single-cycle CPU core's load/store port and upstream of the data block RAM.
- Takes a byte address, store data, write flag and DMType from the core.
- Drives word-addressed RAM with per-lane write enables. Returns aligned, sign/zero-extended load data with a ready handshake.
- Detects misaligned accesses; the core stalls on it while busy=1.

Parameters:
ADDR_W, 10, word-address width of the data RAM (RAM holds 2^ADDR_W 32-bit words)
RD_LATENCY, 1, cycles from ram_en asserted to ram_rdata valid (legal range 1..4)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
cpu_req  input  1  access request, sampled only in IDLE
cpu_we  input  1  1=store, 0=load
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data (low bits used for byte/half)
cpu_dmtype  input  3  000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned
cpu_rdata  output  32  extended load data
cpu_ready  output  1  one-cycle completion pulse
cpu_err  output  1  misaligned flag, valid with cpu_ready
busy  output  1  high in every state except IDLE
ram_en  output  1  RAM enable
ram_addr  output  ADDR_W  word address = latched cpu_addr[ADDR_W+1:2]
ram_wea  output  4  byte write enables, bit i = bits 8i+7:8i
ram_wdata  output  32  lane-replicated store data
ram_rdata  input  32  RAM read data

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset sampled high: state goes to IDLE; cpu_rdata, cpu_ready, cpu_err, busy, ram_en, ram_wea, ram_addr and ram_wdata all go to 0; the latch registers clear. Reset mid-access aborts it with no ready pulse. A write already in its WRITE cycle is not undone.
- States: IDLE, WRITE, READ, RDWAIT, RESP. All outputs are registered or decoded from state plus latched values only; nothing depends combinationally on cpu_* inputs.
- IDLE, cpu_req=1 at an edge: latch addr, wdata, we and dmtype.
  - Misaligned access (half/half-u with addr[0]=1, or word / undefined dmtype with addr[1:0]!=0): go to RESP with err set.
  - Aligned store: go to WRITE.
  - Aligned load: go to READ.
- WRITE (1 cycle): ram_en=1, ram_wea and ram_wdata set from the latched access, cpu_ready=1. Then IDLE. Store completes in the cycle after the request edge.
- READ (1 cycle): ram_en=1, ram_wea=0. Then RDWAIT with counter=RD_LATENCY-1.
- RDWAIT: counter decrements each cycle. When it reads 0, capture the extracted ram_rdata into cpu_rdata and go to RESP. Load ready arrives RD_LATENCY+2 cycles after the request edge (3 at default).
- RESP (1 cycle): cpu_ready=1; cpu_err=1 only for a misaligned access. On error cpu_rdata is unchanged and no RAM access occurs. Then IDLE.
- Handshake: cpu_req is ignored outside IDLE. The core must drop cpu_req in the ready cycle; a req still high in IDLE starts a new access (back-to-back allowed, no idle gap required).
- Store lanes (o = addr[1:0]):
  - Word: wea=1111, wdata=cpu_wdata.
  - Half: wea=0011 if o[1]=0 else 1100; wdata={2{wdata[15:0]}}.
  - Byte: wea=0001<<o; wdata={4{wdata[7:0]}}.
  - ram_wea=0 in every state except WRITE.
- Load extract: shift ram_rdata right by 8*o.
  - Byte: sign-extend from bit 7; byte-u: zero-extend.
  - Half: sign-extend from bit 15; half-u: zero-extend.
  - Word and undefined dmtype: pass through unchanged.
- ram_addr holds its last value in IDLE. Address bits above ADDR_W+1 are ignored (wrap-around).

Test Plan:
- Reset mid-load: assert reset while in RDWAIT -> next cycle busy=0, ram_en=0, cpu_ready never pulses, cpu_rdata=0.
- Store byte: req we=1 addr=0x0000_0006 dmtype=011 wdata=0x1234_56AB -> one cycle later ram_wea=0100, ram_wdata=0xABAB_ABAB, ram_addr=1, cpu_ready=1 the same cycle.
- Load half signed: RAM word1=0x8001_7FFF, addr=0x6, dmtype=001 -> cpu_rdata=0xFFFF_8001, ready at cycle 3; same access with dmtype=010 -> 0x0000_8001.
- Load byte: addr=0x5, dmtype=011, word=0x0000_F200 -> 0xFFFF_FFF2; dmtype=100 -> 0x0000_00F2.
- Misaligned: word load at addr=0x2 -> cycle 1 cpu_ready=1 and cpu_err=1, ram_en never high, cpu_rdata unchanged; halfword store at addr=0x3 -> same, with ram_wea held at 0.
- Back-to-back and latency: RD_LATENCY=3, a word load immediately followed by a word store with req held high -> load ready at cycle 5; store WRITE cycle follows with exactly one ready pulse per access.
